// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache in front of a line-granular
// backing memory (valid/ready request channel plus a response strobe).
module data_cache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 32 - 4 - $clog2(NUM_SETS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_din,
  output logic                     ready,
  output logic                     resp_valid,
  output logic [31:0]              resp_dout,
  output logic                     resp_hit,
  output logic                     mem_req_valid,
  output logic                     mem_req_write,
  output logic [31:0]              mem_req_addr,
  output logic [LINE_WORDS*32-1:0] mem_req_data,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [LINE_WORDS*32-1:0] mem_resp_data,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int IDX = $clog2(NUM_SETS);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, next_state;

  logic [NUM_SETS-1:0]              valid_q, dirty_q;
  logic [TAG_W-1:0]                 tag_mem  [NUM_SETS];
  logic [LINE_WORDS-1:0][31:0]      line_mem [NUM_SETS];

  logic        lat_write;
  logic [31:0] lat_addr, lat_din;
  logic        miss_flag, mem_sent;
  logic [31:0] hit_cnt, miss_cnt;

  logic [IDX-1:0]              idx;
  logic [TAG_W-1:0]            tag;
  logic [1:0]                  off;
  logic [LINE_WORDS-1:0][31:0] cur_line;
  logic                        hit, mem_done;
  logic                        unused_lsbs;

  assign idx         = lat_addr[4 +: IDX];
  assign tag         = lat_addr[31 -: TAG_W];
  assign off         = lat_addr[3:2];
  assign cur_line    = line_mem[idx];
  assign hit         = valid_q[idx] && (tag_mem[idx] == tag);
  assign unused_lsbs = ^lat_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A memory transaction completes on its strobe once accepted; the strobe may
  // coincide with the accept cycle. Strobes with nothing outstanding never match.
  always_comb begin
    next_state    = state;
    ready         = 1'b0;
    resp_valid    = 1'b0;
    resp_dout     = '0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_done      = 1'b0;
    hit_count     = hit_cnt;
    miss_count    = miss_cnt;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req_valid) next_state = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_dout  = cur_line[off];
          resp_hit   = !miss_flag;
          next_state = IDLE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          next_state = WRITEBACK;
        end else begin
          next_state = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_valid = !mem_sent;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_mem[idx], idx, 4'b0000};
        mem_req_data  = cur_line;
        mem_done      = mem_resp_valid && (mem_sent || mem_req_ready);
        if (mem_done) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid = !mem_sent;
        mem_req_addr  = {lat_addr[31:4], 4'b0000};
        mem_done      = mem_resp_valid && (mem_sent || mem_req_ready);
        if (mem_done) next_state = COMPARE;
      end
      default: next_state = IDLE;
    endcase
    if (reset) begin
      ready         = 1'b0;
      resp_valid    = 1'b0;
      resp_dout     = '0;
      resp_hit      = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_req_data  = '0;
      mem_done      = 1'b0;
      hit_count     = '0;
      miss_count    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      miss_flag <= 1'b0;
      mem_sent  <= 1'b0;
    end else begin
      if (mem_done)                           mem_sent <= 1'b0;
      else if (mem_req_valid && mem_req_ready) mem_sent <= 1'b1;
      case (state)
        IDLE: if (req_valid) miss_flag <= 1'b0;
        COMPARE: begin
          if (hit) begin
            if (lat_write) dirty_q[idx] <= 1'b1;
            if (miss_flag) miss_cnt <= miss_cnt + 32'd1;
            else           hit_cnt  <= hit_cnt + 32'd1;
          end else begin
            miss_flag <= 1'b1;
          end
        end
        WRITEBACK: if (mem_done) dirty_q[idx] <= 1'b0;
        ALLOCATE: begin
          if (mem_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath storage: request latch, line data and tags carry no reset.
  always_ff @(posedge clk) begin
    if (ready && req_valid) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_din   <= req_din;
    end
    if (resp_valid && lat_write) line_mem[idx][off] <= lat_din;
    if (state == ALLOCATE && mem_done) begin
      line_mem[idx] <= mem_resp_data;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: reference tag/word model feeds response and memory-request
// scoreboards; a backing-memory model with programmable stall and latency answers.
`timescale 1ns/1ps
module tb_data_cache;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [31:0]  req_addr = '0, req_din = '0;
  logic         ready, resp_valid, resp_hit;
  logic [31:0]  resp_dout;
  logic         mem_req_valid, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;
  logic [31:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  data_cache #(.NUM_SETS(16), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_din(req_din),
    .ready(ready), .resp_valid(resp_valid), .resp_dout(resp_dout), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {logic wr; logic [31:0] addr; logic [127:0] data;} memop_t;
  typedef struct {logic wr; logic hit; logic [31:0] dout;} resp_t;

  memop_t exp_ops[$];
  resp_t  exp_resp[$];

  logic [127:0] bmem    [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [15:0]  rvalid, rdirty;
  logic [23:0]  rtag [16];
  int           exp_hits = 0, exp_miss = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a >> 2) - 32'd15;
  endfunction

  function automatic logic [31:0] bmem_word(input logic [31:0] a);
    logic [31:0]  la;
    logic [127:0] l;
    la = {a[31:4], 4'b0000};
    if (bmem.exists(la)) begin
      l = bmem[la];
      return l[32*a[3:2] +: 32];
    end
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return bmem_word(wa);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = ref_word(la + 32'(4*i));
    return l;
  endfunction

  function automatic logic [127:0] bline(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = bmem_word(la + 32'(4*i));
    return l;
  endfunction

  // Backing memory model
  int           stall_req = 0, stall_cnt = 0, latency = 2, lat_cnt = 0;
  bit           outstanding = 0;
  logic [127:0] rd_data, first_data;
  logic [31:0]  first_addr;
  memop_t       mop;

  always @(negedge clk) begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (outstanding) begin
      if (mem_req_valid) chk("dup_req", mem_req_valid, 1'b0);
      if (lat_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = rd_data;
        outstanding    = 0;
      end else begin
        lat_cnt--;
      end
    end else if (mem_req_valid) begin
      if (stall_cnt == 0) begin
        first_addr = mem_req_addr;
        first_data = mem_req_data;
      end else begin
        chk("stall_addr", mem_req_addr, first_addr);
        chk("stall_data", mem_req_data, first_data);
      end
      if (stall_cnt < stall_req) begin
        chk("stall_ready", ready, 1'b0);
        stall_cnt++;
      end else begin
        mem_req_ready = 1'b1;
        stall_cnt = 0;
        stall_req = 0;
        if (exp_ops.size() == 0) chk("memop_unexpected", mem_req_addr, 32'hFFFF_FFFF);
        else begin
          mop = exp_ops.pop_front();
          chk("memop_write", mem_req_write, mop.wr);
          chk("memop_addr", mem_req_addr, mop.addr);
          if (mop.wr) chk("memop_data", mem_req_data, mop.data);
        end
        if (mem_req_write) begin
          bmem[mem_req_addr] = mem_req_data;
          rd_data = '0;
        end else begin
          rd_data = bline(mem_req_addr);
        end
        if (latency == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = rd_data;
        end else begin
          outstanding = 1;
          lat_cnt = latency - 1;
        end
      end
    end else begin
      stall_cnt = 0;
    end
  end

  resp_t rsp;
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", resp_dout, 32'hFFFF_FFFF);
      else begin
        rsp = exp_resp.pop_front();
        chk("resp_hit", resp_hit, rsp.hit);
        if (!rsp.wr) chk("resp_dout", resp_dout, rsp.dout);
      end
    end
  end

  task automatic ref_reset();
    rvalid = '0;
    rdirty = '0;
    ref_mem.delete();
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] din);
    logic [3:0]  sidx;
    logic [23:0] tg;
    logic [31:0] wa;
    bit          hit;
    resp_t       r;
    memop_t      op;
    int          cyc;
    sidx = addr[7:4];
    tg   = addr[31:8];
    wa   = {addr[31:2], 2'b00};
    hit  = rvalid[sidx] && (rtag[sidx] == tg);
    if (!hit) begin
      if (rvalid[sidx] && rdirty[sidx]) begin
        op.wr   = 1'b1;
        op.addr = {rtag[sidx], sidx, 4'b0000};
        op.data = ref_line(op.addr);
        exp_ops.push_back(op);
      end
      op.wr   = 1'b0;
      op.addr = {addr[31:4], 4'b0000};
      op.data = '0;
      exp_ops.push_back(op);
      rvalid[sidx] = 1'b1;
      rtag[sidx]   = tg;
      rdirty[sidx] = 1'b0;
    end
    if (wr) begin
      ref_mem[wa]  = din;
      rdirty[sidx] = 1'b1;
    end
    r.wr   = wr;
    r.hit  = hit;
    r.dout = wr ? 32'h0 : ref_word(wa);
    exp_resp.push_back(r);
    if (hit) exp_hits++;
    else     exp_miss++;

    cyc = 0;
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!ready) chk("ready_timeout", ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_din   = din;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_din   = $urandom;
    cyc = 1;
    while (!resp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!resp_valid) chk("resp_timeout", resp_valid, 1'b1);
    else if (hit)    chk("hit_latency", cyc, 1);
    @(negedge clk);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
  endtask

  logic [31:0] pool [7] = '{32'h040, 32'h140, 32'h240, 32'h200, 32'h300, 32'h0A0, 32'h1A0};

  initial begin
    int     cyc;
    memop_t op;
    ref_reset();

    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", ready, 1'b1);
    chk("hit_count_rst", hit_count, 0);
    chk("miss_count_rst", miss_count, 0);

    latency = 3;
    do_req(1'b0, 32'h040, 32'h0);
    do_req(1'b0, 32'h048, 32'h0);
    do_req(1'b1, 32'h044, 32'hDEAD_BEEF);
    stall_req = 5;
    latency   = 2;
    do_req(1'b0, 32'h140, 32'h0);
    latency = 0;
    do_req(1'b1, 32'h208, 32'h1234_5678);
    do_req(1'b0, 32'h208, 32'h0);
    latency = 1;
    do_req(1'b0, 32'h308, 32'h0);

    repeat (24) begin
      stall_req = $urandom_range(0, 2);
      latency   = $urandom_range(0, 3);
      do_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 6)] + 32'(4 * $urandom_range(0, 3)),
             $urandom);
    end

    // Reset while the fill is outstanding; the late strobe must be ignored.
    latency = 12;
    op.wr = 1'b0; op.addr = 32'h0B0; op.data = '0;
    exp_ops.push_back(op);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0B0; req_din = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!outstanding && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("alloc_outstanding", outstanding, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", ready, 1'b0);
    chk("rst_mid_mem_req_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    ref_reset();
    chk("post_rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_miss_count", miss_count, 0);
    cyc = 0;
    while (outstanding && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("late_strobe_no_resp", resp_valid, 1'b0);
    chk("late_strobe_ready", ready, 1'b1);
    latency = 2;
    do_req(1'b0, 32'h0B0, 32'h0);
    do_req(1'b0, 32'h044, 32'h0);

    // Reset while a request is being held off by mem_req_ready.
    stall_req = 40;
    op.wr = 1'b0; op.addr = 32'h0C0; op.data = '0;
    exp_ops.push_back(op);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C4; req_din = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!mem_req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stalled_req_seen", mem_req_valid, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst2_mem_req_valid", mem_req_valid, 1'b0);
    chk("post_rst2_ready", ready, 1'b1);
    stall_req = 0;
    exp_ops.delete();
    ref_reset();
    do_req(1'b0, 32'h0C4, 32'h0);
    do_req(1'b0, 32'h0C8, 32'h0);

    chk("resp_queue_drained", exp_resp.size(), 0);
    chk("memop_queue_drained", exp_ops.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Acts as the responder to the pipeline's MEM-stage load/store requests, replacing the single-cycle data memory.
- Backed by a multi-cycle line-granular memory over a valid/ready request channel plus a response strobe.
- Hits complete one cycle after acceptance; misses stall the requester via `ready` until the line is refilled.

Parameters:
- NUM_SETS, 16, number of lines; power of two, ≥2; index width IDX = log2(NUM_SETS).
- LINE_WORDS, 4, 32-bit words per line; fixed at 4 (16-byte lines), offset = addr[3:2].
- TAG_W, 32-4-IDX, tag width = addr[31:4+IDX].

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address; bits [1:0] ignored
- req_din  input  32  store data
- ready  output  1  cache can accept a request this cycle
- resp_valid  output  1  one-cycle strobe: request completed
- resp_dout  output  32  load data; valid only with resp_valid
- resp_hit  output  1  completed request hit on first lookup
- mem_req_valid  output  1  line request to backing memory
- mem_req_write  output  1  1 = line writeback, 0 = line fill
- mem_req_addr  output  32  line-aligned address, bits [3:0] = 0
- mem_req_data  output  128  victim line, word 0 in [31:0]
- mem_req_ready  input  1  memory accepts the request this cycle
- mem_resp_valid  input  1  read data or write ack strobe
- mem_resp_data  input  128  fill line, word 0 in [31:0]
- hit_count  output  32  completed first-lookup hits
- miss_count  output  32  completed requests that missed

Behaviour:
- Storage:
  - Per set: valid, dirty, tag, and a 4×32 data array.
  - Flops only; no SRAM macro.
- Reset:
  - Clears all valid and dirty bits and both counters.
  - State goes to IDLE.
  - All outputs are 0 during the reset cycle, including `ready`; `ready` = 1 from the first cycle after reset deassertion.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - `ready` = 1.
  - On req_valid&&ready, latch write/addr/din, clear the miss flag, and go to COMPARE.
  - `ready` = 0 in every other state.
- COMPARE (lookup on latched address):
  - Hit = valid && tag match.
  - On hit:
    - `resp_valid` = 1 this cycle.
    - Load: `resp_dout` = word[offset].
    - Store: write word[offset] and set dirty at the clock edge.
    - `resp_hit` = !miss flag.
    - Increment hit_count if no miss flag, else miss_count.
    - Go to IDLE.
  - On miss:
    - Set the miss flag; no response.
    - If valid&&dirty, go to WRITEBACK; else go to ALLOCATE.
- WRITEBACK:
  - Drive `mem_req_valid` = 1, `mem_req_write` = 1, address = {victim tag, index, 4'b0}, data = victim line.
  - Hold all of these stable until the cycle mem_req_ready = 1.
  - Deassert from the next cycle, then wait for mem_resp_valid.
  - On ack, clear dirty and go to ALLOCATE.
- ALLOCATE:
  - Same handshake with `mem_req_write` = 0 and the requested line address.
  - On mem_resp_valid, write the line and tag, set valid, clear dirty, and go to COMPARE (guaranteed hit).
- mem_resp_valid in the same cycle as the accept is legal and is treated as the response.
- mem_resp_valid while no transaction is outstanding is ignored.
- Latency: hit = 1 cycle from accept to `resp_valid`. Clean miss = 1 + handshake + memory latency + 1. Dirty miss adds one full writeback transaction.
- A new request may be accepted the cycle after `resp_valid` (IDLE); there is no back-to-back accept in the same cycle as a response.
- Requester rule: inputs are sampled only on accept, so changes to req_* while `ready` = 0 have no effect.
- Counters wrap modulo 2^32.
- Reset mid-operation (any state):
  - Returns to IDLE and drops any in-flight memory transaction; `mem_req_valid` = 0 from the cycle after the reset edge.
  - Late mem_resp_valid strobes are ignored.
  - Dirty data is lost; this is accepted.
- Address aliasing: requests differing only in tag map to the same set and evict each other.

Test Plan:
- Cold load: reset, then load 0x0000_0040. Required: mem read of 0x40; memory returns {0x4,0x3,0x2,0x1}; `resp_valid` with `resp_dout` = 0x1, `resp_hit` = 0; miss_count = 1.
- Warm hit: then load 0x0000_0048. Required: `resp_valid` exactly 1 cycle after accept, `resp_dout` = 0x3, `resp_hit` = 1, no mem request; hit_count = 1.
- Store hit then dirty eviction: store 0xDEAD_BEEF to 0x44, then load 0x0000_0140 (same set, NUM_SETS = 16). Required: first a mem write to 0x40 with `mem_req_data` = {0x4,0x3,0xDEAD_BEEF,0x1}; then a mem read of 0x140.
- Stalled handshake: hold mem_req_ready = 0 for 5 cycles. Required: `mem_req_valid`, `mem_req_addr` and `mem_req_data` stable throughout; `ready` = 0 throughout; one accepted request only.
- Store miss (write-allocate): store 0x1234_5678 to 0x0000_0208 on a clean set. Required: line fill from 0x200; word 2 becomes 0x1234_5678 and dirty = 1; a later load of 0x208 hits and returns 0x1234_5678.
- Reset mid-ALLOCATE: assert reset while waiting for mem_resp_valid. Required: `mem_req_valid` = 0 next cycle; a late mem_resp_valid is ignored; a subsequent load of the same address misses (valid cleared).
